// File: rtl/scan_chain_ctrl_if.sv
// Handshake and data bundle between a scan chain controller and its environment.
// The controller attaches through the slave modport.
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 32
) ();
  logic                 start;
  logic                 capture_en;
  logic                 abort;
  logic [CHAIN_LEN-1:0] load_data;
  logic                 so;
  logic                 se;
  logic                 si;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] unload_data;

  modport master (
    output start, capture_en, abort, load_data, so,
    input  se, si, busy, done, unload_data
  );

  modport slave (
    input  start, capture_en, abort, load_data, so,
    output se, si, busy, done, unload_data
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a pattern in, optionally pulses one capture cycle,
// then shifts the chain contents out into unload_data.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned CNT_W     = 8
) (
  input logic               CP,
  input logic               CDN,
  scan_chain_ctrl_if.slave  bus
);
  localparam int unsigned IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCapture, StUnload, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [CHAIN_LEN-1:0] r_pattern, w_pattern_d;
  logic [CHAIN_LEN-1:0] r_unload, w_unload_d;
  logic                 r_cap_en, w_cap_en_d;
  logic                 r_se, r_si, r_busy, r_done;
  logic                 w_last;
  logic [IDX_W-1:0]     w_idx_q, w_idx_d;

  assign w_last  = (r_cnt == LAST);
  assign w_idx_q = r_cnt[IDX_W-1:0];
  assign w_idx_d = w_cnt_d[IDX_W-1:0];

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_pattern_d = r_pattern;
    w_cap_en_d  = r_cap_en;
    w_unload_d  = r_unload;
    // Abort wins over everything, including a start seen in the same cycle.
    if (bus.abort) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            w_state_d   = StLoad;
            w_cnt_d     = '0;
            w_pattern_d = bus.load_data;
            w_cap_en_d  = bus.capture_en;
          end
        end
        StLoad: begin
          if (w_last) begin
            w_state_d = r_cap_en ? StCapture : StUnload;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StCapture: begin
          w_state_d = StUnload;
          w_cnt_d   = '0;
        end
        StUnload: begin
          w_unload_d[w_idx_q] = bus.so;
          if (w_last) begin
            w_state_d = StDone;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StDone: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_pattern <= '0;
      r_cap_en  <= 1'b0;
      r_unload  <= '0;
      r_se      <= 1'b0;
      r_si      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pattern <= w_pattern_d;
      r_cap_en  <= w_cap_en_d;
      r_unload  <= w_unload_d;
      r_se      <= (w_state_d == StLoad) || (w_state_d == StUnload);
      r_si      <= (w_state_d == StLoad) && w_pattern_d[w_idx_d];
      r_busy    <= (w_state_d != StIdle);
      r_done    <= (w_state_d == StDone);
    end
  end

  assign bus.se          = r_se;
  assign bus.si          = r_si;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.unload_data = r_unload;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: models the scan chain behind the controller and scores
// each sequence's done latency and unloaded contents against a queue of expectations.
module tb_scan_chain_ctrl;
  logic clk = 1'b0;
  logic cdn = 1'b0;
  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(32)) if32 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(2))  if2 ();

  scan_chain_ctrl #(.CHAIN_LEN(32), .CNT_W(8)) dut32 (.CP(clk), .CDN(cdn), .bus(if32.slave));
  scan_chain_ctrl #(.CHAIN_LEN(2),  .CNT_W(2)) dut2  (.CP(clk), .CDN(cdn), .bus(if2.slave));

  // Chain models: shift toward the last cell while se=1, optionally capture ones when se=0.
  logic [31:0] chain32  = '0;
  logic [1:0]  chain2   = '0;
  logic        cap_ones = 1'b0;
  always @(posedge clk) begin
    if (if32.se)       chain32 <= {chain32[30:0], if32.si};
    else if (cap_ones) chain32 <= '1;
    if (if2.se)        chain2  <= {chain2[0], if2.si};
    else if (cap_ones) chain2  <= '1;
  end
  assign if32.so = chain32[31];
  assign if2.so  = chain2[1];

  typedef struct {
    logic [31:0] load;
    logic        cap;
    logic        ones;
    logic [31:0] exp_unload;
  } vec_t;

  typedef struct {
    logic [31:0] unload;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] last_unload = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // act: 0 plain, 1 abort at act_cyc, 2 start pulse with alt_ld at act_cyc, 3 reset at act_cyc.
  task automatic run32(input logic [31:0] ld, input logic cap, input int act, input int act_cyc,
                       input logic [31:0] alt_ld, input logic [31:0] exp_unload,
                       input int exp_se_low_at);
    int          got_lat = 0;
    int          se_low_cnt = 0;
    int          se_low_at = 0;
    logic [31:0] got_unload = '0;
    exp_t        e;
    if (act == 0 || act == 2) sb.push_back('{exp_unload, 2 * 32 + 1 + (cap ? 1 : 0)});
    @(negedge clk);
    if32.start = 1'b1; if32.load_data = ld; if32.capture_en = cap;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) if32.start = 1'b0;
      if (if32.done && got_lat == 0) begin
        got_lat = k;
        got_unload = if32.unload_data;
      end
      if (if32.busy && !if32.done && !if32.se) begin
        se_low_cnt++;
        se_low_at = k;
      end
      if (act == 1 && k == act_cyc) if32.abort = 1'b1;
      if (act == 1 && k == act_cyc + 1) begin
        if32.abort = 1'b0;
        check("abort busy", {31'b0, if32.busy}, 32'h0);
        check("abort se", {31'b0, if32.se}, 32'h0);
        check("abort unload held", if32.unload_data, last_unload);
      end
      if (act == 2 && k == act_cyc) begin
        if32.start = 1'b1; if32.load_data = alt_ld;
      end
      if (act == 2 && k == act_cyc + 1) if32.start = 1'b0;
      if (act == 3 && k == act_cyc) begin
        cdn = 1'b0;
        #1;
        check("reset outs", {28'b0, if32.se, if32.si, if32.busy, if32.done}, 32'h0);
        check("reset unload", if32.unload_data, 32'h0);
        last_unload = '0;
      end
      if (act == 3 && k == act_cyc + 3) cdn = 1'b1;
      if (got_lat != 0 && (act == 0 || act == 2)) break;
    end
    if (act == 0 || act == 2) begin
      if (sb.size() == 0) begin
        check("scoreboard empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check("done latency", got_lat, e.lat);
        check("unload data", got_unload, e.unload);
        last_unload = e.unload;
      end
      check("se low count", se_low_cnt, cap ? 32'd1 : 32'd0);
      check("se low cycle", se_low_at, exp_se_low_at);
    end else begin
      check("no done", got_lat, 32'h0);
      check("unload after", if32.unload_data, last_unload);
    end
  endtask

  task automatic run2(input logic [1:0] ld, input logic [1:0] exp_unload);
    int          got_lat = 0;
    logic [31:0] got_unload = '0;
    exp_t        e;
    sb.push_back('{{30'b0, exp_unload}, 2 * 2 + 1});
    @(negedge clk);
    if2.start = 1'b1; if2.load_data = ld; if2.capture_en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) if2.start = 1'b0;
      if (if2.done && got_lat == 0) begin
        got_lat = k;
        got_unload = {30'b0, if2.unload_data};
      end
      if (got_lat != 0) break;
    end
    e = sb.pop_front();
    check("len2 latency", got_lat, e.lat);
    check("len2 unload", got_unload, e.unload);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'hA5C3_0F1E, 1'b0, 1'b0, 32'hA5C3_0F1E};
    vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001};
    vecs[3] = '{32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678};
    vecs[4] = '{32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF};

    if32.start = 1'b0; if32.capture_en = 1'b0; if32.abort = 1'b0; if32.load_data = '0;
    if2.start  = 1'b0; if2.capture_en  = 1'b0; if2.abort  = 1'b0; if2.load_data  = '0;
    #12;
    check("rst outs", {28'b0, if32.se, if32.si, if32.busy, if32.done}, 32'h0);
    check("rst unload", if32.unload_data, 32'h0);
    @(negedge clk);
    cdn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cap_ones = vecs[i].ones;
      run32(vecs[i].load, vecs[i].cap, 0, 0, '0, vecs[i].exp_unload, vecs[i].cap ? 33 : 0);
    end
    cap_ones = 1'b0;

    // Abort during LOAD, then a clean sequence.
    run32(32'h3C3C_5A5A, 1'b0, 1, 10, '0, '0, 0);
    run32(32'h0F0F_1234, 1'b0, 0, 0, '0, 32'h0F0F_1234, 0);

    // Start pulse during UNLOAD cycle 5 is ignored.
    run32(32'hCAFE_0001, 1'b0, 2, 32 + 1 + 5, 32'hDEAD_BEEF, 32'hCAFE_0001, 0);

    // Reset during UNLOAD cycle 7, then a loopback of 1.
    run32(32'h5555_AAAA, 1'b0, 3, 32 + 1 + 7, '0, '0, 0);
    run32(32'h0000_0001, 1'b0, 0, 0, '0, 32'h0000_0001, 0);

    // Abort and start together in IDLE: stay idle.
    @(negedge clk);
    if32.start = 1'b1; if32.abort = 1'b1; if32.load_data = 32'h7777_7777;
    @(negedge clk);
    if32.start = 1'b0; if32.abort = 1'b0;
    check("abort+start busy", {31'b0, if32.busy}, 32'h0);
    @(negedge clk);
    check("abort+start idle", {30'b0, if32.busy, if32.se}, 32'h0);

    run2(2'b10, 2'b10);
    run2(2'b01, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
